// File: rtl/nios_system_sysid_checker_if.sv
// Avalon-MM read-only bus between the sysid checker (master) and the system-ID slave.
interface nios_system_sysid_checker_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/nios_system_sysid_checker.sv
// Reads the system-ID and timestamp words over Avalon-MM and compares them against
// the values this software image was built for; a stall watchdog bounds each read.
module nios_system_sysid_checker #(
    parameter logic [31:0] BASE_ADDRESS       = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1346452407,
    parameter logic [7:0]  TIMEOUT_CYCLES     = 8'd255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               start,
    nios_system_sysid_checker_if.master        avm,
    output logic                               busy,
    output logic                               done,
    output logic                               id_match,
    output logic                               ts_match,
    output logic                               timeout,
    output logic [31:0]                        id_value,
    output logic [31:0]                        ts_value
);

    localparam logic [31:0] TS_ADDRESS = BASE_ADDRESS + 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        RD_ID,
        RD_TS,
        FINISH
    } state_e;

    state_e      state_q;
    logic        read_q;
    logic [31:0] addr_q;
    logic        busy_q;
    logic        done_q;
    logic        id_match_q;
    logic        ts_match_q;
    logic        timeout_q;
    logic [31:0] id_value_q;
    logic [31:0] ts_value_q;
    logic [7:0]  stall_cnt_q;
    logic [7:0]  stall_cnt_d;
    logic        stall_hit;
    logic        auto_q;

    // stall_hit fires on the stalled cycle that brings the count up to TIMEOUT_CYCLES,
    // so the read strobe is held for exactly TIMEOUT_CYCLES stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q + 8'd1;
        stall_hit   = (stall_cnt_d == TIMEOUT_CYCLES);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            read_q      <= 1'b0;
            addr_q      <= BASE_ADDRESS;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            id_match_q  <= 1'b0;
            ts_match_q  <= 1'b0;
            timeout_q   <= 1'b0;
            id_value_q  <= '0;
            ts_value_q  <= '0;
            stall_cnt_q <= '0;
            auto_q      <= AUTO_START;
        end else begin
            auto_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start || auto_q) begin
                        state_q     <= RD_ID;
                        read_q      <= 1'b1;
                        addr_q      <= BASE_ADDRESS;
                        busy_q      <= 1'b1;
                        id_match_q  <= 1'b0;
                        ts_match_q  <= 1'b0;
                        timeout_q   <= 1'b0;
                        stall_cnt_q <= '0;
                    end
                end
                RD_ID: begin
                    if (!avm.avm_waitrequest) begin
                        id_value_q  <= avm.avm_readdata;
                        state_q     <= RD_TS;
                        addr_q      <= TS_ADDRESS;
                        stall_cnt_q <= '0;
                    end else if (stall_hit) begin
                        state_q   <= FINISH;
                        read_q    <= 1'b0;
                        addr_q    <= BASE_ADDRESS;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        stall_cnt_q <= stall_cnt_d;
                    end
                end
                RD_TS: begin
                    if (!avm.avm_waitrequest) begin
                        // Match flags are registered on entry to FINISH so they are valid with done.
                        ts_value_q <= avm.avm_readdata;
                        id_match_q <= (id_value_q == EXPECTED_ID);
                        ts_match_q <= (avm.avm_readdata == EXPECTED_TIMESTAMP);
                        state_q    <= FINISH;
                        read_q     <= 1'b0;
                        addr_q     <= BASE_ADDRESS;
                        done_q     <= 1'b1;
                    end else if (stall_hit) begin
                        state_q   <= FINISH;
                        read_q    <= 1'b0;
                        addr_q    <= BASE_ADDRESS;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        stall_cnt_q <= stall_cnt_d;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign avm.avm_read    = read_q;
    assign avm.avm_address = addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign id_match        = id_match_q;
    assign ts_match        = ts_match_q;
    assign timeout         = timeout_q;
    assign id_value        = id_value_q;
    assign ts_value        = ts_value_q;

    a_stable_while_stalled: assert property (@(posedge clock) disable iff (!reset_n)
        (read_q && avm.avm_waitrequest && !stall_hit) |=> (read_q && $stable(addr_q)));

    a_idle_address: assert property (@(posedge clock) disable iff (!reset_n)
        !read_q |-> (addr_q == BASE_ADDRESS));

    a_done_implies_busy: assert property (@(posedge clock) disable iff (!reset_n)
        done_q |-> busy_q);

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Scoreboard bench for the sysid checker: an Avalon slave model with configurable
// stalls, plus a second instance with a short watchdog for the timeout path.
module tb_nios_system_sysid_checker;

    localparam logic [31:0] TS_EXP  = 32'd1346452407;
    localparam logic [31:0] TS_ADDR = 32'h0000_0004;
    localparam logic [31:0] BASE2   = 32'h0000_1000;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        start2  = 1'b0;
    logic        busy, done, id_match, ts_match, timeout;
    logic [31:0] id_value, ts_value;
    logic        busy2, done2, id_match2, ts_match2, timeout2;
    logic [31:0] id_value2, ts_value2;

    always #5 clock = ~clock;

    nios_system_sysid_checker_if bus ();
    nios_system_sysid_checker_if bus2 ();

    nios_system_sysid_checker #(
        .BASE_ADDRESS      (32'h0000_0000),
        .EXPECTED_ID       (32'h0000_0000),
        .EXPECTED_TIMESTAMP(TS_EXP),
        .TIMEOUT_CYCLES    (8'd255),
        .AUTO_START        (1'b1)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .avm     (bus),
        .busy    (busy),
        .done    (done),
        .id_match(id_match),
        .ts_match(ts_match),
        .timeout (timeout),
        .id_value(id_value),
        .ts_value(ts_value)
    );

    nios_system_sysid_checker #(
        .BASE_ADDRESS  (BASE2),
        .TIMEOUT_CYCLES(8'd4),
        .AUTO_START    (1'b0)
    ) dut2 (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start2),
        .avm     (bus2),
        .busy    (busy2),
        .done    (done2),
        .id_match(id_match2),
        .ts_match(ts_match2),
        .timeout (timeout2),
        .id_value(id_value2),
        .ts_value(ts_value2)
    );

    typedef struct {
        logic        id_m;
        logic        ts_m;
        logic        to;
        logic [31:0] idv;
        logic [31:0] tsv;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    exp_t        mon_e;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    int unsigned stall_cfg = 0;
    logic [31:0] id_data   = '0;
    logic [31:0] ts_data   = '0;
    logic        in_txn    = 1'b0;
    int unsigned txn_cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc++;

    // Slave model: stall each read for stall_cfg cycles, return garbage while stalled.
    always @(negedge clock) begin
        if (bus.avm_read) begin
            if (!in_txn) begin
                in_txn  = 1'b1;
                txn_cyc = 0;
            end else begin
                txn_cyc++;
            end
            bus.avm_waitrequest = (txn_cyc < stall_cfg);
            if (bus.avm_waitrequest)             bus.avm_readdata = 32'hBAD0_BAD0;
            else if (bus.avm_address == 32'h0)   bus.avm_readdata = id_data;
            else if (bus.avm_address == TS_ADDR) bus.avm_readdata = ts_data;
            else                                 bus.avm_readdata = 32'hBAD0_BAD0;
            if (addr_q.size() > 0) check("avm_address", bus.avm_address, addr_q[0]);
            else                   check("unexpected_read", bus.avm_read, 1'b0);
            if (!bus.avm_waitrequest) begin
                in_txn = 1'b0;
                if (addr_q.size() > 0) void'(addr_q.pop_front());
            end
        end else begin
            in_txn              = 1'b0;
            bus.avm_waitrequest = 1'b0;
            bus.avm_readdata    = 32'hBAD0_BAD0;
            check("idle_address", bus.avm_address, 32'h0);
        end
    end

    always @(negedge clock) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", done, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_cycle", cyc, mon_e.cyc);
                check("done_busy", busy, 1'b1);
                check("id_match", id_match, mon_e.id_m);
                check("ts_match", ts_match, mon_e.ts_m);
                check("timeout", timeout, mon_e.to);
                check("id_value", id_value, mon_e.idv);
                check("ts_value", ts_value, mon_e.tsv);
            end
        end
    end

    initial begin
        bus2.avm_waitrequest = 1'b1;
        bus2.avm_readdata    = '0;
    end

    task automatic expect_check(input logic [31:0] idd, input logic [31:0] tsd, input int unsigned stalls);
        exp_t e;
        id_data   = idd;
        ts_data   = tsd;
        stall_cfg = stalls;
        e.id_m = (idd == 32'h0);
        e.ts_m = (tsd == TS_EXP);
        e.to   = 1'b0;
        e.idv  = idd;
        e.tsv  = tsd;
        e.cyc  = cyc + 3 + 2 * stalls;
        exp_q.push_back(e);
        addr_q.push_back(32'h0);
        addr_q.push_back(TS_ADDR);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_read"}, bus.avm_read, 1'b0);
        check({tag, "_addr"}, bus.avm_address, 32'h0);
        check({tag, "_id_match"}, id_match, 1'b0);
        check({tag, "_ts_match"}, ts_match, 1'b0);
        check({tag, "_timeout"}, timeout, 1'b0);
        check({tag, "_id_value"}, id_value, 32'h0);
        check({tag, "_ts_value"}, ts_value, 32'h0);
    endtask

    initial begin
        int unsigned n;
        int unsigned reads;
        int unsigned dones;

        repeat (3) @(negedge clock);
        check_reset("rst_init");

        // Auto-start after release, no stalls
        @(negedge clock); #2;
        expect_check(32'h0, TS_EXP, 0);
        reset_n = 1'b1;
        wait_idle("auto_done");

        // Wrong ID, then confirm results hold in IDLE
        @(negedge clock);
        expect_check(32'h0000_0001, TS_EXP, 0);
        pulse_start();
        wait_idle("id_mismatch_done");
        repeat (4) @(negedge clock);
        check("hold_id_match", id_match, 1'b0);
        check("hold_ts_match", ts_match, 1'b1);
        check("hold_id_value", id_value, 32'h1);
        check("hold_ts_value", ts_value, TS_EXP);

        // Five wait states per read
        @(negedge clock);
        expect_check(32'h0, TS_EXP, 5);
        pulse_start();
        wait_idle("stall5_done");

        // Wrong timestamp with one wait state
        @(negedge clock);
        expect_check(32'h0, 32'hDEAD_BEEF, 1);
        pulse_start();
        wait_idle("ts_mismatch_done");

        // Extra start during RD_TS, and start during FINISH
        @(negedge clock);
        expect_check(32'h0, TS_EXP, 2);
        pulse_start();
        n = 0;
        while (!(bus.avm_read && bus.avm_address == TS_ADDR) && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("reach_rd_ts", bus.avm_read, 1'b1);
        pulse_start();
        n = 0;
        while (!done && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("reach_finish", done, 1'b1);
        pulse_start();
        repeat (2) @(negedge clock);
        check("finish_start_ignored", busy, 1'b0);
        check("extra_start_no_result", exp_q.size(), 0);

        // Reset in the middle of RD_ID, then auto restart
        @(negedge clock);
        expect_check(32'h0, TS_EXP, 3);
        pulse_start();
        @(negedge clock); #2;
        reset_n = 1'b0;
        #1;
        check_reset("rst_mid");
        exp_q.delete();
        addr_q.delete();
        repeat (2) begin
            @(negedge clock);
            check("rst_hold_done", done, 1'b0);
            check("rst_hold_read", bus.avm_read, 1'b0);
        end
        @(negedge clock); #2;
        expect_check(32'h0, TS_EXP, 3);
        reset_n = 1'b1;
        wait_idle("restart_done");

        // Watchdog on the second instance: slave never releases waitrequest
        @(negedge clock);
        check("to_idle_addr", bus2.avm_address, BASE2);
        start2 = 1'b1;
        @(negedge clock);
        start2 = 1'b0;
        reads = 0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus2.avm_read) begin
                reads++;
                check("to_read_addr", bus2.avm_address, BASE2);
            end
            if (done2) dones++;
            @(negedge clock);
        end
        check("to_read_cycles", reads, 4);
        check("to_done_count", dones, 1);
        check("to_timeout", timeout2, 1'b1);
        check("to_id_match", id_match2, 1'b0);
        check("to_ts_match", ts_match2, 1'b0);
        check("to_busy", busy2, 1'b0);
        check("to_addr_after", bus2.avm_address, BASE2);

        check("sb_empty", exp_q.size() + addr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/nios_system_sysid_checker.md
NIOS_SYSTEM_SYSID_CHECKER -- requirements
Module: nios_system_sysid_checker

Interface
REQ-001 The block SHALL have one clock domain; reset SHALL be asynchronous and active-low, and the ports SHALL be named clock and reset_n.
REQ-002 Parameter BASE_ADDRESS, 32'h0000_0000, byte address of the system-ID slave; ID word at +0, timestamp word at +4.
REQ-003 Parameter EXPECTED_ID, 32'h0000_0000, value the ID word must equal.
REQ-004 Parameter EXPECTED_TIMESTAMP, 32'd1346452407, value the timestamp word must equal.
REQ-005 Parameter TIMEOUT_CYCLES, 8'd255, maximum stalled cycles per read (range 1..255).
REQ-006 Parameter AUTO_START, 1, when 1 a check starts automatically after reset release.
REQ-007 clock  input  1  system clock, all logic on rising edge.
REQ-008 reset_n  input  1  asynchronous active-low reset.
REQ-009 start  input  1  single-cycle request to run a check.
REQ-010 avm_address  output  32  Avalon-MM master byte address.
REQ-011 avm_read  output  1  Avalon-MM read strobe.
REQ-012 avm_readdata  input  32  read data, valid when avm_read=1 and avm_waitrequest=0.
REQ-013 avm_waitrequest  input  1  slave stall.
REQ-014 busy  output  1  check in progress.
REQ-015 done  output  1  one-cycle pulse at end of check.
REQ-016 id_match, ts_match, timeout  output  1 each  sticky result flags.
REQ-017 id_value, ts_value  output  32 each  last captured ID and timestamp words.

Function
REQ-018 The FSM SHALL have states IDLE, RD_ID, RD_TS, FINISH; all outputs SHALL be registered.
REQ-019 IDLE: on start=1 (or first cycle after reset release when AUTO_START=1) the FSM SHALL enter RD_ID on the next edge and clear id_match, ts_match, timeout.
REQ-020 RD_ID: avm_read=1, avm_address=BASE_ADDRESS; on a cycle with avm_waitrequest=0 the FSM SHALL capture avm_readdata into id_value and enter RD_TS.
REQ-021 RD_TS: avm_read=1, avm_address=BASE_ADDRESS+4; on a cycle with avm_waitrequest=0 the FSM SHALL capture avm_readdata into ts_value and enter FINISH.
REQ-022 avm_read and avm_address SHALL remain stable while avm_waitrequest=1.
REQ-023 FINISH (one cycle): avm_read=0, done=1, id_match=(id_value==EXPECTED_ID), ts_match=(ts_value==EXPECTED_TIMESTAMP) unless timeout=1, then return to IDLE.
REQ-024 busy SHALL be 1 in RD_ID, RD_TS and FINISH, 0 in IDLE.
REQ-025 Minimum latency: start at cycle 0, zero wait states -> done=1 at cycle 3.
REQ-026 An 8-bit stall counter SHALL clear on entry to RD_ID and RD_TS and increment each cycle avm_waitrequest=1.
REQ-027 When the counter equals TIMEOUT_CYCLES with avm_waitrequest=1, the FSM SHALL drop avm_read, set timeout=1, force id_match=ts_match=0 and enter FINISH.
REQ-028 start while busy=1 SHALL be ignored; start in the FINISH cycle SHALL be ignored.
REQ-029 Result flags and captured values SHALL hold from FINISH until the next accepted start.
REQ-030 avm_address SHALL read BASE_ADDRESS when avm_read=0.

Reset
REQ-031 On reset_n=0, immediately: state=IDLE, avm_read=0, avm_address=BASE_ADDRESS, busy=0, done=0, flags=0, id_value=ts_value=0, counter=0.
REQ-032 Reset asserted mid-read SHALL abort the transaction without a done pulse; after release, AUTO_START governs restart.

Verification
REQ-033 AUTO_START=1, slave returns 0 then 1346452407, no stalls -> read addr 0 then 4, done at 3rd cycle after release, id_match=1, ts_match=1.
REQ-034 start pulse, slave returns ID 32'h0000_0001 -> done pulse, id_match=0, ts_match=1, id_value=32'h1.
REQ-035 avm_waitrequest=1 for 5 cycles on each read -> address/read stable throughout, done 13 cycles after start, both matches 1.
REQ-036 TIMEOUT_CYCLES=4, avm_waitrequest held 1 -> avm_read drops after 4 stalled cycles, timeout=1, matches 0, done=1 once.
REQ-037 start re-asserted during RD_TS and reset_n pulsed low during RD_ID of a later check -> extra start ignored; reset returns all outputs to REQ-031 values with no done.
